// File: rtl/pulse_sequencer.sv
// Multi-channel delay/width pulse generator sharing one repeat period.
// Timing registers are double-buffered so reprogramming never produces runt pulses.
module pulse_sequencer #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned N_BITS = 20,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [N_BITS-1:0] i_wr_data,
  input  logic              i_trig_in,
  output logic [N_CH-1:0]   o_ch_out,
  output logic              o_cycle_start,
  output logic              o_busy,
  output logic              o_armed,
  output logic              o_missed
);

  localparam logic [N_BITS-1:0] RESET_PERIOD = N_BITS'(800000);
  localparam logic [N_BITS-1:0] MIN_PERIOD   = N_BITS'(2);

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_t;

  state_t            r_state, w_state_next;
  logic [N_BITS-1:0] r_cnt, w_cnt_next;
  logic              r_enable, r_mode, r_missed;
  logic [1:0]        r_trig_sync;
  logic              r_trig_prev;
  logic [N_CH-1:0]   r_ch_out, w_ch_next;

  logic [N_BITS-1:0] r_pend_period, r_act_period;
  logic [N_BITS-1:0] r_pend_delay [N_CH];
  logic [N_BITS-1:0] r_pend_width [N_CH];
  logic [N_BITS-1:0] r_act_delay  [N_CH];
  logic [N_BITS-1:0] r_act_width  [N_CH];

  logic              w_ctrl_wr, w_period_wr;
  logic              w_enable, w_mode, w_soft_trig, w_trig_ext, w_trig;
  logic              w_load, w_copy, w_missed_set;
  logic [N_BITS-1:0] w_p, w_last;

  assign w_ctrl_wr   = i_wr_en && (i_wr_addr == ADDR_W'(1));
  assign w_period_wr = i_wr_en && (i_wr_addr == '0);

  // A control write acts in the same cycle it is issued.
  assign w_enable    = w_ctrl_wr ? i_wr_data[0] : r_enable;
  assign w_mode      = w_ctrl_wr ? i_wr_data[1] : r_mode;
  assign w_soft_trig = w_ctrl_wr && i_wr_data[2];
  assign w_trig_ext  = r_trig_sync[1] && !r_trig_prev;
  assign w_trig      = w_trig_ext || w_soft_trig;

  assign w_p    = (r_act_period < MIN_PERIOD) ? MIN_PERIOD : r_act_period;
  assign w_last = w_p - N_BITS'(1);

  // Active timing follows pending while stopped, and latches on entry to each period.
  assign w_copy = w_load || (r_state != StRun);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_trig_sync <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_sync <= {r_trig_sync[0], i_trig_in};
      r_trig_prev <= r_trig_sync[1];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_missed_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (w_enable) begin
          if (w_mode) begin
            w_state_next = StArmed;
          end else begin
            w_state_next = StRun;
            w_load       = 1'b1;
          end
        end
      end
      StArmed: begin
        w_cnt_next = '0;
        if (!w_enable) begin
          w_state_next = StIdle;
        end else if (w_trig) begin
          w_state_next = StRun;
          w_load       = 1'b1;
        end
      end
      StRun: begin
        if (!w_enable) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_missed_set = w_trig;
          if (r_cnt >= w_last) begin
            w_cnt_next = '0;
            if (w_mode) begin
              w_state_next = StArmed;
            end else begin
              w_load = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + N_BITS'(1);
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Window sum is one bit wider so delay + width never wraps.
  always_comb begin
    w_ch_next = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_ch_next[k] = (r_state == StRun) && w_enable &&
                     ({1'b0, r_cnt} >= {1'b0, r_act_delay[k]}) &&
                     ({1'b0, r_cnt} < ({1'b0, r_act_delay[k]} + {1'b0, r_act_width[k]}));
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_ch_out <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ch_out <= w_ch_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_enable <= 1'b0;
      r_mode   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= i_wr_data[0];
        r_mode   <= i_wr_data[1];
      end
      if (w_missed_set) begin
        r_missed <= 1'b1;
      end else if (w_ctrl_wr) begin
        r_missed <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_period <= RESET_PERIOD;
      r_act_period  <= RESET_PERIOD;
      for (int k = 0; k < N_CH; k++) begin
        r_pend_delay[k] <= '0;
        r_pend_width[k] <= '0;
        r_act_delay[k]  <= '0;
        r_act_width[k]  <= '0;
      end
    end else begin
      if (w_period_wr) begin
        r_pend_period <= i_wr_data;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (i_wr_en && (i_wr_addr == ADDR_W'(2 + 2 * k))) begin
          r_pend_delay[k] <= i_wr_data;
        end
        if (i_wr_en && (i_wr_addr == ADDR_W'(3 + 2 * k))) begin
          r_pend_width[k] <= i_wr_data;
        end
      end
      if (w_copy) begin
        r_act_period <= r_pend_period;
        for (int k = 0; k < N_CH; k++) begin
          r_act_delay[k] <= r_pend_delay[k];
          r_act_width[k] <= r_pend_width[k];
        end
      end
    end
  end

  assign o_ch_out      = r_ch_out;
  assign o_cycle_start = (r_state == StRun) && (r_cnt == '0);
  assign o_busy        = (r_state == StRun);
  assign o_armed       = (r_state == StArmed);
  assign o_missed      = r_missed;

endmodule
